// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI-addressed parameter memory.
package spi_pkg;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_MEM_DEPTH = 256;
   localparam int unsigned DEF_AUTO_INC  = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHK_CMD   = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_ADD  = 3'd3,
      ST_READ_DATA = 3'd4
   } state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram.sv
// Single-port synchronous RAM, one-cycle registered read; contents are never reset.
module spi_ram
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
   input  logic                         clk,
   input  logic                         en,
   input  logic                         we,
   input  logic [$clog2(MEM_DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]            din,
   output logic [DATA_W-1:0]            dout
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= din;
         else    dout      <= mem[addr];
      end
   end

endmodule

// File: rtl/spi_param_wrapper.sv
// SPI-style slave giving serial access to an internal RAM through separate
// write and read address pointers; all logic runs on clk, SS_n/MOSI are sampled.
module spi_param_wrapper
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int unsigned AUTO_INC  = DEF_AUTO_INC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy,
   output logic frame_err
);

   localparam int unsigned ADDR_W  = $clog2(MEM_DEPTH);
   localparam int unsigned FRAME_W = DATA_W + 2;
   localparam int unsigned CNT_W   = $clog2(DATA_W + 4);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0] TX_START = CNT_W'(DATA_W + 1);
   localparam logic [CNT_W-1:0] TX_FIRST = CNT_W'(DATA_W);

   if (ADDR_W > DATA_W || MEM_DEPTH < 2) begin : g_param_chk
      $error("spi_param_wrapper: need ADDR_W <= DATA_W and MEM_DEPTH >= 2");
   end

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [FRAME_W-1:0]  sh, sh_d;
   logic [ADDR_W-1:0]   wr_addr, wr_addr_d;
   logic [ADDR_W-1:0]   rd_addr, rd_addr_d;
   logic [CNT_W-1:0]    tx_cnt, tx_cnt_d;
   logic [DATA_W-1:0]   tx_sh, tx_sh_d;
   logic                miso_d, err_d;

   logic [1:0]          op_c;
   logic [DATA_W-1:0]   payload_c;
   logic                ram_en_c, ram_we_c;
   logic [ADDR_W-1:0]   ram_addr_c;
   logic [DATA_W-1:0]   ram_dout;

   assign op_c      = sh[FRAME_W-1 -: 2];
   assign payload_c = sh[DATA_W-1:0];

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   spi_ram #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en_c),
      .we   (ram_we_c),
      .addr (ram_addr_c),
      .din  (payload_c),
      .dout (ram_dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         sh        <= '0;
         wr_addr   <= '0;
         rd_addr   <= '0;
         tx_cnt    <= '0;
         tx_sh     <= '0;
         MISO      <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         sh        <= sh_d;
         wr_addr   <= wr_addr_d;
         rd_addr   <= rd_addr_d;
         tx_cnt    <= tx_cnt_d;
         tx_sh     <= tx_sh_d;
         MISO      <= miso_d;
         busy      <= (state_d != ST_IDLE);
         frame_err <= err_d;
      end
   end

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      sh_d       = sh;
      wr_addr_d  = wr_addr;
      rd_addr_d  = rd_addr;
      tx_cnt_d   = tx_cnt;
      tx_sh_d    = tx_sh;
      miso_d     = 1'b0;
      err_d      = 1'b0;
      ram_en_c   = 1'b0;
      ram_we_c   = 1'b0;
      ram_addr_c = rd_addr;

      // Read shifter: one idle cycle for RAM latency, then MSB first.
      if (tx_cnt != '0) begin
         tx_cnt_d = tx_cnt - CNT_W'(1);
         if (tx_cnt == TX_FIRST) begin
            miso_d  = ram_dout[DATA_W-1];
            tx_sh_d = ram_dout << 1;
         end else if (tx_cnt < TX_FIRST) begin
            miso_d  = tx_sh[DATA_W-1];
            tx_sh_d = tx_sh << 1;
         end
      end

      unique case (state)
         ST_IDLE: begin
            cnt_d = '0;
            if (!SS_n) state_d = ST_CHK_CMD;
         end
         ST_CHK_CMD: begin
            if (!SS_n) state_d = MOSI ? ST_READ_ADD : ST_WRITE;
         end
         default: begin
            if (cnt == CNT_FULL) begin
               // Frame complete: commit exactly once, then ignore MOSI.
               cnt_d = CNT_DONE;
               if (state == ST_WRITE) begin
                  if (op_c == OP_WR_ADDR) begin
                     wr_addr_d = payload_c[ADDR_W-1:0];
                  end else if (op_c == OP_WR_DATA) begin
                     ram_en_c   = 1'b1;
                     ram_we_c   = 1'b1;
                     ram_addr_c = wr_addr;
                     if (AUTO_INC != 0) wr_addr_d = addr_inc(wr_addr);
                  end
               end else if (state == ST_READ_ADD) begin
                  if (op_c == OP_RD_ADDR) rd_addr_d = payload_c[ADDR_W-1:0];
               end else begin
                  ram_en_c = 1'b1;
                  tx_cnt_d = TX_START;
                  if (AUTO_INC != 0) rd_addr_d = addr_inc(rd_addr);
               end
            end else if (cnt < CNT_FULL && !SS_n) begin
               sh_d  = {sh[FRAME_W-2:0], MOSI};
               cnt_d = cnt + CNT_W'(1);
               // op[1] must repeat the command bit, otherwise drop the frame.
               if (cnt == '0 && (MOSI != (state != ST_WRITE))) begin
                  err_d = 1'b1;
                  cnt_d = CNT_DONE;
               end
               if (cnt == CNT_W'(1) && state == ST_READ_ADD && {sh[0], MOSI} == OP_RD_DATA)
                  state_d = ST_READ_DATA;
            end
         end
      endcase

      // Deselect always returns to IDLE; an unfinished frame is an abort.
      if (state != ST_IDLE && SS_n) begin
         state_d  = ST_IDLE;
         tx_cnt_d = '0;
         miso_d   = 1'b0;
         if (cnt < CNT_FULL) err_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_param_wrapper.sv
// Scoreboard bench: stimulus queues expected read words and error pulses,
// a bus monitor decodes frames and pops/compares as the DUT produces them.
module tb_spi_param_wrapper;

   logic clk = 1'b0;
   logic rst_n;
   logic ss8, ss16, mosi;
   logic miso8, miso16, busy8, busy16, err8, err16;
   bit   sel;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      bit          is_err;
      logic [15:0] data;
   } item_t;

   item_t exp_q[$];

   logic cur_ss, cur_miso, cur_busy, cur_err;
   assign cur_ss   = sel ? ss16   : ss8;
   assign cur_miso = sel ? miso16 : miso8;
   assign cur_busy = sel ? busy16 : busy8;
   assign cur_err  = sel ? err16  : err8;

   always #5 clk = ~clk;

   spi_param_wrapper dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SS_n      (ss8),
      .MOSI      (mosi),
      .MISO      (miso8),
      .busy      (busy8),
      .frame_err (err8)
   );

   spi_param_wrapper #(
      .DATA_W    (16),
      .MEM_DEPTH (1024),
      .AUTO_INC  (1)
   ) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .SS_n      (ss16),
      .MOSI      (mosi),
      .MISO      (miso16),
      .busy      (busy16),
      .frame_err (err16)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_pop(input bit is_err, input logic [15:0] d);
      item_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL sb_unexpected: got err=%0b data=%h want nothing at %0t", is_err, d, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.is_err != is_err || e.data !== d) begin
            bad++;
            $display("FAIL sb_item: got err=%0b data=%h want err=%0b data=%h at %0t",
                     is_err, d, e.is_err, e.data, $time);
         end
      end
   endtask

   task automatic set_ss(input logic v);
      if (sel) ss16 = v;
      else     ss8  = v;
   endtask

   // Sends C, op, payload MSB first; nbits<0 sends the whole frame.
   task automatic frame(input bit c, input logic [1:0] op, input logic [15:0] pay,
                        input int nbits, input int tail, input bit keep);
      int w, n, lim;
      logic b;
      w   = sel ? 16 : 8;
      n   = 3 + w;
      lim = (nbits < 0 || nbits > n) ? n : nbits;
      @(negedge clk);
      set_ss(1'b0);
      mosi = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (i == 0)      b = c;
         else if (i == 1) b = op[1];
         else if (i == 2) b = op[0];
         else             b = pay[w + 2 - i];
         @(negedge clk);
         mosi = b;
      end
      if (lim == n) begin
         for (int i = 0; i < tail; i++) begin
            @(negedge clk);
            mosi = 1'b1;
         end
      end
      if (!keep) begin
         @(negedge clk);
         set_ss(1'b1);
         mosi = 1'b0;
         @(negedge clk);
         check("busy_after_deselect", 16'(cur_busy), 16'h0);
         @(negedge clk);
      end
   endtask

   task automatic cmd(input logic [1:0] op, input logic [15:0] pay);
      frame(op[1], op, pay, -1, 2, 1'b0);
   endtask

   task automatic expect_err();
      exp_q.push_back('{is_err: 1'b1, data: 16'h0});
   endtask

   task automatic rd_expect(input logic [15:0] d);
      exp_q.push_back('{is_err: 1'b0, data: d});
      frame(1'b1, 2'b11, 16'h0, -1, (sel ? 16 : 8) + 3, 1'b0);
   endtask

   // Bus monitor: k indexes clk edges since SS_n fell (0 = IDLE->CHK_CMD).
   initial begin : monitor
      int k, w;
      bit c, win;
      logic [1:0]  op;
      logic [15:0] got;
      k = 0; c = 1'b0; op = 2'b00; got = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         w   = sel ? 16 : 8;
         win = 1'b0;
         if (!rst_n || cur_ss) begin
            k = 0;
         end else begin
            if (k == 0) begin c = 1'b0; op = 2'b00; got = 16'h0; end
            if (k == 1) c = mosi;
            if (k == 2) op[1] = mosi;
            if (k == 3) op[0] = mosi;
            if (c && op == 2'b11 && k >= 6 + w && k <= 5 + 2 * w) begin
               win = 1'b1;
               got = {got[14:0], cur_miso};
               if (k == 5 + 2 * w) sb_pop(1'b0, got);
            end
            k++;
         end
         if (!win) check("miso_idle", 16'(cur_miso), 16'h0);
         if (cur_err) sb_pop(1'b1, 16'h0);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst_n = 1'b0; ss8 = 1'b1; ss16 = 1'b1; mosi = 1'b0; sel = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_miso8",   16'(miso8),       16'h0);
      check("rst_busy8",   16'(busy8),       16'h0);
      check("rst_err8",    16'(err8),        16'h0);
      check("rst_miso16",  16'(miso16),      16'h0);
      check("rst_busy16",  16'(busy16),      16'h0);
      check("rst_rd_addr", 16'(dut.rd_addr), 16'h0);
      check("rst_wr_addr", 16'(dut.wr_addr), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic write then read back.
      cmd(2'b00, 16'h000A);
      cmd(2'b01, 16'h0055);
      cmd(2'b10, 16'h000A);
      rd_expect(16'h0055);

      // Write pointer wraps 0xFF -> 0x00; read pointer wraps the same way.
      cmd(2'b00, 16'h00FF);
      cmd(2'b01, 16'h00A1);
      cmd(2'b01, 16'h00B2);
      cmd(2'b01, 16'h00C3);
      cmd(2'b10, 16'h00FF);
      rd_expect(16'h00A1);
      rd_expect(16'h00B2);
      rd_expect(16'h00C3);

      // Aborted write after 5 of 11 bits: no memory or pointer change.
      cmd(2'b00, 16'h0020);
      cmd(2'b01, 16'h0077);
      cmd(2'b00, 16'h0020);
      expect_err();
      frame(1'b0, 2'b01, 16'h0033, 5, 0, 1'b0);
      cmd(2'b10, 16'h0020);
      rd_expect(16'h0077);
      cmd(2'b01, 16'h0044);
      cmd(2'b10, 16'h0020);
      rd_expect(16'h0044);

      // op[1] disagreeing with C discards the frame.
      cmd(2'b10, 16'h000A);
      expect_err();
      frame(1'b0, 2'b10, 16'h00FF, -1, 2, 1'b0);
      rd_expect(16'h0055);
      expect_err();
      frame(1'b1, 2'b01, 16'h0099, -1, 2, 1'b0);
      cmd(2'b01, 16'h0066);
      cmd(2'b10, 16'h0021);
      rd_expect(16'h0066);

      // Reset in the middle of shift-out.
      cmd(2'b10, 16'h000A);
      frame(1'b1, 2'b11, 16'h0, -1, 5, 1'b1);
      check("busy_mid_read", 16'(busy8), 16'h1);
      rst_n = 1'b0; ss8 = 1'b1; mosi = 1'b0;
      #1;
      check("rst_mid_miso",    16'(miso8),       16'h0);
      check("rst_mid_busy",    16'(busy8),       16'h0);
      check("rst_mid_rd_addr", 16'(dut.rd_addr), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd_expect(16'h00B2);
      cmd(2'b01, 16'h005A);
      cmd(2'b10, 16'h0000);
      rd_expect(16'h005A);

      // 16-bit data, 1024 words.
      sel = 1'b1;
      @(negedge clk);
      cmd(2'b00, 16'h03FF);
      cmd(2'b01, 16'hBEEF);
      cmd(2'b10, 16'h03FF);
      rd_expect(16'hBEEF);
      cmd(2'b01, 16'h1234);
      cmd(2'b10, 16'h0000);
      rd_expect(16'h1234);
      cmd(2'b10, 16'hFFFF);
      rd_expect(16'hBEEF);

      repeat (5) @(negedge clk);
      check("sb_left_over", 16'(exp_q.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_param_wrapper.md
SPI_PARAM_WRAPPER -- requirements
Module: spi_param_wrapper

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the payload and memory word width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, meaning the number of memory words; ADDR_W = clog2(MEM_DEPTH).
REQ-003 SHALL have parameter AUTO_INC, default 1, meaning the stored address increments after each data access when set to 1.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port SS_n, input, 1 bit, slave select, active low, sampled on clk.
REQ-007 SHALL have port MOSI, input, 1 bit, serial data in, sampled on clk.
REQ-008 SHALL have port MISO, output, 1 bit, serial read data, MSB first.
REQ-009 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-010 SHALL have port frame_err, output, 1 bit, a one-cycle pulse on an aborted or malformed frame.

Function
REQ-011 SHALL run the FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 SHALL take the transition IDLE->CHK_CMD on the first edge with SS_n=0.
REQ-013 SHALL, in CHK_CMD, sample command bit C: C=0 -> WRITE; C=1 -> READ_ADD.
REQ-014 SHALL shift a frame after C made of op[1:0] then DATA_W payload bits, all MSB first.
REQ-015 SHALL decode op as: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-016 SHALL, if op[1] != C, pulse frame_err and discard the frame, with no memory or address change.
REQ-017 SHALL, in READ_ADD, branch on op=11 to READ_DATA after the op bits; the payload bits are then dummy bits.
REQ-018 SHALL, on op 00, latch payload[ADDR_W-1:0] into wr_addr on the edge after the last payload bit.
REQ-019 SHALL, on op 10, latch payload[ADDR_W-1:0] into rd_addr on the edge after the last payload bit.
REQ-020 SHALL, on op 01, write the payload to mem[wr_addr] on the edge after the last payload bit.
REQ-021 SHALL, after an op 01 write with AUTO_INC=1, set wr_addr to wr_addr+1, wrapping from MEM_DEPTH-1 to 0.
REQ-022 SHALL, on op 11, issue the read of mem[rd_addr] on the edge after the last dummy bit (edge N); read data is valid at N+1.
REQ-023 SHALL drive the read-data MSB on MISO from edge N+2, one bit per cycle for DATA_W cycles.
REQ-024 SHALL, after an op 11 read completes with AUTO_INC=1, increment rd_addr with the same wrap rule.
REQ-025 SHALL hold MISO at 0 except while shifting read data.
REQ-026 SHALL ignore MOSI bits beyond the frame length until SS_n=1.
REQ-027 SHALL, when SS_n=1, return the FSM to IDLE on the next edge.
REQ-028 SHALL treat SS_n rising before the frame completes as an abort: frame_err pulses, no write and no address update occur, and MISO drops to 0.
REQ-029 SHALL give op 11 with no prior op 10 since reset a read from rd_addr=0.
REQ-030 SHALL write mem[wr_addr] only when the frame completes; wr_addr then equals the value latched by the last op 00.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force the FSM to IDLE and set MISO=0, busy=0, frame_err=0, wr_addr=0, rd_addr=0 and the shift/bit counters to 0.
REQ-032 SHALL leave memory contents unaffected by reset.
REQ-033 SHALL, on reset mid-frame, discard the frame entirely.

Structure
REQ-034 SHALL place the FSM state enum, op code constants and the default parameter values in package spi_pkg.
REQ-035 SHALL instantiate the memory as sub-module spi_ram, a single-port synchronous RAM with 1-cycle read latency, parameterised by DATA_W and MEM_DEPTH.
REQ-036 SHALL provide an elaboration-time check that ADDR_W <= DATA_W and MEM_DEPTH >= 2.

Verification
REQ-037 SHALL cover with defaults: op 00 addr 0x0A, then op 01 data 0x55, then op 10 0x0A, then op 11 -> MISO returns 0x55, MSB first, starting 2 cycles after the last dummy bit.
REQ-038 SHALL cover with AUTO_INC=1: op 00 0xFF, then op 01 0xA1, then op 01 0xB2 -> mem[0xFF]=0xA1 and mem[0x00]=0xB2 (wrap), with wr_addr=0x01 afterwards.
REQ-039 SHALL cover SS_n raised after 5 of 11 bits of an op 01 with data 0x33 -> frame_err pulses once, the memory is unchanged and the FSM is in IDLE the next cycle.
REQ-040 SHALL cover C=0 with op=10 -> frame_err pulses and rd_addr is unchanged.
REQ-041 SHALL cover DATA_W=16, MEM_DEPTH=1024: write 0xBEEF to address 0x3FF, then read it back -> MISO returns 0xBEEF over 16 cycles.
REQ-042 SHALL cover rst_n pulsed low mid op 11 shift-out -> MISO=0, busy=0, and rd_addr=0 immediately.
